// File: rtl/serial_delta_converter_if.sv
// Serial link bundle for serial_delta_converter.
// PAR_ERR exists only when SERIAL_DELTA_PARITY_EN is defined.
interface serial_delta_converter_if #(
   parameter int WIDTH = 8,
   parameter int CW = 4
);
   logic X;
   logic Y;
   logic Y_VALID;
   logic SKIP;
   logic [CW-1:0] FRAME_CNT;
   logic [WIDTH-1:0] OLD_Q;
`ifdef SERIAL_DELTA_PARITY_EN
   logic PAR_ERR;
`endif

   modport master (
      output X,
`ifdef SERIAL_DELTA_PARITY_EN
      input PAR_ERR,
`endif
      input Y, Y_VALID, SKIP, FRAME_CNT, OLD_Q
   );

   modport slave (
      input X,
`ifdef SERIAL_DELTA_PARITY_EN
      output PAR_ERR,
`endif
      output Y, Y_VALID, SKIP, FRAME_CNT, OLD_Q
   );
endinterface

// File: rtl/serial_delta_converter.sv
// Forwards framed serial words on Y only when they differ from the last one sent.
// Define SERIAL_DELTA_PARITY_EN to add an even-parity bit and PAR_ERR.
module serial_delta_converter #(
   parameter int WIDTH = 8,
   parameter int CW = 4,
   parameter logic [WIDTH-1:0] OLD_INIT = '0,
   parameter bit FIRST_ALWAYS = 1'b1
) (
   input logic CLOCK,
   input logic RESET,
   serial_delta_converter_if.slave bus
);
`ifdef SERIAL_DELTA_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int CNTW = $clog2(WIDTH + 2);
   localparam logic [CNTW-1:0] RX_LAST = CNTW'(WIDTH - 1 + PBITS);
   localparam logic [CNTW-1:0] TX_LAST = CNTW'(WIDTH - 1);
   localparam logic [CNTW-1:0] DATA_BITS = CNTW'(WIDTH);

   typedef enum logic [1:0] {IDLE, RECV, CMP, XMIT} state_t;

   state_t state, state_n;
   logic [CNTW-1:0] cnt;
   logic [WIDTH-1:0] din, dout, old_q;
   logic [CW-1:0] frame_cnt;
   logic seen, skip;
   logic fwd, par_bad, rx_done, tx_done;

`ifdef SERIAL_DELTA_PARITY_EN
   logic par, par_err;
   assign par_bad = ^{din, par};
   assign bus.PAR_ERR = par_err;
`else
   assign par_bad = 1'b0;
`endif

   // First frame after reset may be forced through even if it matches
   assign fwd = (din != old_q) || (FIRST_ALWAYS && !seen);
   assign rx_done = (cnt == RX_LAST);
   assign tx_done = (cnt == TX_LAST);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (bus.X) state_n = RECV;
         RECV: if (rx_done) state_n = CMP;
         CMP: begin
            if (!par_bad && fwd) state_n = XMIT;
            else state_n = IDLE;
         end
         XMIT: if (tx_done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= IDLE;
         cnt <= '0;
         din <= '0;
         dout <= '0;
         old_q <= OLD_INIT;
         frame_cnt <= '0;
         seen <= 1'b0;
         skip <= 1'b0;
`ifdef SERIAL_DELTA_PARITY_EN
         par <= 1'b0;
         par_err <= 1'b0;
`endif
      end else begin
         state <= state_n;
         skip <= 1'b0;
`ifdef SERIAL_DELTA_PARITY_EN
         par_err <= 1'b0;
`endif
         unique case (state)
            IDLE: cnt <= '0;
            RECV: begin
               cnt <= rx_done ? '0 : cnt + 1'b1;
               if (cnt < DATA_BITS) din <= {din[WIDTH-2:0], bus.X};
`ifdef SERIAL_DELTA_PARITY_EN
               else par <= bus.X;
`endif
            end
            CMP: begin
               cnt <= '0;
               if (par_bad) begin
`ifdef SERIAL_DELTA_PARITY_EN
                  par_err <= 1'b1;
`endif
               end else if (fwd) begin
                  old_q <= din;
                  dout <= din;
                  seen <= 1'b1;
                  frame_cnt <= frame_cnt + 1'b1;
               end else begin
                  skip <= 1'b1;
               end
            end
            XMIT: begin
               dout <= {dout[WIDTH-2:0], 1'b0};
               cnt <= tx_done ? '0 : cnt + 1'b1;
            end
            default: cnt <= '0;
         endcase
      end
   end

   assign bus.Y_VALID = (state == XMIT);
   assign bus.Y = bus.Y_VALID & dout[WIDTH-1];
   assign bus.SKIP = skip;
   assign bus.FRAME_CNT = frame_cnt;
   assign bus.OLD_Q = old_q;
endmodule

// File: tb/tb_serial_delta_converter.sv
// Scoreboard bench for serial_delta_converter: two instances
// (defaults, and CW=2 with FIRST_ALWAYS=0) share one X stream.
module tb_serial_delta_converter;
   localparam int W = 8;
`ifdef SERIAL_DELTA_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic x = 1'b0;
   int cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_delta_converter_if #(.WIDTH(8), .CW(4)) ia ();
   serial_delta_converter_if #(.WIDTH(8), .CW(2)) ib ();
   assign ia.X = x;
   assign ib.X = x;

   serial_delta_converter #(
      .WIDTH(8), .CW(4), .OLD_INIT(8'h00), .FIRST_ALWAYS(1'b1)
   ) ua (.CLOCK(clk), .RESET(rst), .bus(ia));

   serial_delta_converter #(
      .WIDTH(8), .CW(2), .OLD_INIT(8'h00), .FIRST_ALWAYS(1'b0)
   ) ub (.CLOCK(clk), .RESET(rst), .bus(ib));

   logic pe0, pe1;
`ifdef SERIAL_DELTA_PARITY_EN
   assign pe0 = ia.PAR_ERR;
   assign pe1 = ib.PAR_ERR;
`else
   assign pe0 = 1'b0;
   assign pe1 = 1'b0;
`endif

   // kind: 0 forwarded, 1 skipped, 2 parity error
   typedef struct {
      int kind;
      logic [7:0] word;
      int fc;
      logic [7:0] old;
      int ev;
   } item_t;

   item_t q0[$];
   item_t q1[$];
   item_t cur[2];
   logic [7:0] m_old[2];
   bit m_seen[2];
   int m_fc[2];
   int nb[2];
   logic [7:0] sh[2];
   bit lowc[2];

   task automatic chk(input string n, input int k,
                      input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h required=%0h",
                  n, k, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_old[k] = 8'h00;
         m_seen[k] = 1'b0;
         m_fc[k] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_frame(input logic [7:0] w, input bit pok,
                              input int t, output bit any_fwd);
      any_fwd = 1'b0;
      for (int k = 0; k < 2; k++) begin
         item_t it;
         it.ev = t + W + 1 + P;
         it.word = w;
         if (!pok) it.kind = 2;
         else if (w != m_old[k] || (k == 0 && !m_seen[k])) begin
            it.kind = 0;
            m_old[k] = w;
            m_seen[k] = 1'b1;
            m_fc[k] = (m_fc[k] + 1) % (k == 0 ? 16 : 4);
            any_fwd = 1'b1;
         end else it.kind = 1;
         it.fc = m_fc[k];
         it.old = m_old[k];
         if (k == 0) q0.push_back(it);
         else q1.push_back(it);
      end
   endtask

   task automatic drive_frame(input logic [7:0] w, input bit pok,
                              input bit hold, output int t, output bit f);
      x = 1'b1;
      @(negedge clk);
      t = cyc;
      for (int i = W - 1; i >= 0; i--) begin
         x = w[i];
         @(negedge clk);
      end
      if (P == 1) begin
         x = pok ? ^w : ~^w;
         @(negedge clk);
      end
      model_frame(w, pok, t, f);
      x = hold;
   endtask

   task automatic send(input logic [7:0] w, input bit pok,
                       input bit hold, input int gap);
      int t;
      bit f;
      drive_frame(w, pok, hold, t, f);
      repeat (f ? W + 1 : 1) @(negedge clk);
      x = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic take(input int k, output item_t it, output bit ok);
      ok = 1'b1;
      if (k == 0) begin
         if (q0.size() == 0) ok = 1'b0;
         else it = q0.pop_front();
      end else begin
         if (q1.size() == 0) ok = 1'b0;
         else it = q1.pop_front();
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL unexpected_event dut%0d cyc=%0d got=event required=none",
                  k, cyc);
      end
   endtask

   task automatic mon(input int k, input logic yv, input logic y,
                      input logic sk, input logic pe,
                      input logic [3:0] fc, input logic [7:0] oq);
      item_t it;
      bit ok;
      if (rst) begin
         nb[k] = 0;
         lowc[k] = 1'b0;
         return;
      end
      if (lowc[k]) begin
         chk("yvalid_len", k, 32'(yv), 32'd0);
         lowc[k] = 1'b0;
      end
      if (!yv) chk("y_idle", k, 32'(y), 32'd0);
      if (yv) begin
         if (nb[k] == 0) begin
            take(k, it, ok);
            if (ok) begin
               cur[k] = it;
               chk("fwd_kind", k, 32'(it.kind), 32'd0);
               chk("y_start", k, 32'(cyc), 32'(it.ev));
               chk("fwd_cnt", k, 32'(fc), 32'(it.fc));
               chk("fwd_old", k, 32'(oq), 32'(it.old));
            end
         end
         sh[k] = {sh[k][6:0], y};
         nb[k]++;
         if (nb[k] == W) begin
            chk("y_word", k, 32'(sh[k]), 32'(cur[k].word));
            nb[k] = 0;
            lowc[k] = 1'b1;
         end
      end
      if (sk) begin
         take(k, it, ok);
         if (ok) begin
            chk("skip_kind", k, 32'(it.kind), 32'd1);
            chk("skip_time", k, 32'(cyc), 32'(it.ev));
            chk("skip_cnt", k, 32'(fc), 32'(it.fc));
            chk("skip_old", k, 32'(oq), 32'(it.old));
         end
      end
      if (pe) begin
         take(k, it, ok);
         if (ok) begin
            chk("perr_kind", k, 32'(it.kind), 32'd2);
            chk("perr_time", k, 32'(cyc), 32'(it.ev));
            chk("perr_cnt", k, 32'(fc), 32'(it.fc));
            chk("perr_old", k, 32'(oq), 32'(it.old));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, ia.Y_VALID, ia.Y, ia.SKIP, pe0, ia.FRAME_CNT, ia.OLD_Q);
      mon(1, ib.Y_VALID, ib.Y, ib.SKIP, pe1, 4'(ib.FRAME_CNT), ib.OLD_Q);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bit f;
      logic [7:0] lastw;
      logic [7:0] w;
      bit pok;
      nb[0] = 0;
      nb[1] = 0;
      lowc[0] = 1'b0;
      lowc[1] = 1'b0;
      model_reset();
      do_reset();

      chk("rst_y", 0, 32'(ia.Y), 32'd0);
      chk("rst_yvalid", 0, 32'(ia.Y_VALID), 32'd0);
      chk("rst_skip", 0, 32'(ia.SKIP), 32'd0);
      chk("rst_cnt", 0, 32'(ia.FRAME_CNT), 32'd0);
      chk("rst_old", 0, 32'(ia.OLD_Q), 32'd0);
      chk("rst_yvalid", 1, 32'(ib.Y_VALID), 32'd0);
      chk("rst_cnt", 1, 32'(ib.FRAME_CNT), 32'd0);
      chk("rst_old", 1, 32'(ib.OLD_Q), 32'd0);
`ifdef SERIAL_DELTA_PARITY_EN
      chk("rst_perr", 0, 32'(ia.PAR_ERR), 32'd0);
      chk("rst_perr", 1, 32'(ib.PAR_ERR), 32'd0);
`endif

      send(8'hA5, 1'b1, 1'b0, 2);
      send(8'hA5, 1'b1, 1'b0, 2);
      send(8'h3C, 1'b1, 1'b0, 0);
      repeat (2) @(negedge clk);

`ifdef SERIAL_DELTA_PARITY_EN
      do_reset();
      send(8'h3C, 1'b0, 1'b0, 1);
      send(8'h3C, 1'b1, 1'b0, 1);
`endif

      do_reset();
      send(8'h00, 1'b1, 1'b0, 1);
      send(8'h01, 1'b1, 1'b0, 1);

      drive_frame(8'hA5, 1'b1, 1'b0, t, f);
      repeat (3) @(negedge clk);
      chk("xmit_live", 0, 32'(ia.Y_VALID), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_yvalid", 0, 32'(ia.Y_VALID), 32'd0);
      chk("abort_old", 0, 32'(ia.OLD_Q), 32'd0);
      chk("abort_cnt", 0, 32'(ia.FRAME_CNT), 32'd0);
      chk("abort_yvalid", 1, 32'(ib.Y_VALID), 32'd0);
      chk("abort_old", 1, 32'(ib.OLD_Q), 32'd0);
      chk("abort_cnt", 1, 32'(ib.FRAME_CNT), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      send(8'hA5, 1'b1, 1'b0, 2);

      do_reset();
      for (int v = 1; v <= 5; v++) send(8'(v), 1'b1, 1'b1, 0);
      x = 1'b0;
      repeat (3) @(negedge clk);

      lastw = 8'h5A;
      for (int i = 0; i < 24; i++) begin
         w = ($urandom_range(0, 2) == 0) ? lastw : 8'($urandom);
         pok = (P == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
         send(w, pok, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
         lastw = w;
      end

      repeat (30) @(negedge clk);
      chk("drained", 0, 32'(q0.size()), 32'd0);
      chk("drained", 1, 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_delta_converter.md
Name: serial_delta_converter

Overview:
- Parametrised sequential successor of the b09 serial-to-serial converter.
- Receives framed serial words on X and compares each word with the last word forwarded.
- Retransmits a word serially on Y only when it differs from that stored word.
- Adds configurable width, first-frame forcing, a skip indication, a frame counter and optional parity checking.
- Sits between a serial sensor link and a downstream serial consumer, filtering out repeated values.

Parameters:
- WIDTH, 8: data bits per frame, minimum 2.
- CW, 4: width of FRAME_CNT.
- OLD_INIT, 0: reset value of the stored word, WIDTH bits.
- FIRST_ALWAYS, 1: when 1, the first frame after reset is always forwarded, even if it equals OLD_INIT.

Ports:
- CLOCK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- X  in  1  serial input: start bit, then WIDTH data bits MSB first, then (parity build only) a parity bit.
- Y  out  1  serial output data, MSB first; 0 when Y_VALID=0.
- Y_VALID  out  1  high while Y carries a data bit.
- SKIP  out  1  one-cycle pulse when a received frame equals the stored word and is suppressed.
- FRAME_CNT  out  CW  count of forwarded frames, wraps modulo 2^CW.
- OLD_Q  out  WIDTH  the stored (last forwarded) word.

Behaviour:
- Interface: one clock, CLOCK; reset is synchronous and active-high, RESET.
- All outputs come from registers or decoded state only; there is no combinational path from X to any output.
- Reset values: state=IDLE, Y=0, Y_VALID=0, SKIP=0, FRAME_CNT=0, OLD_Q=OLD_INIT, seen flag=0, bit counter=0.
- RESET is sampled every edge and overrides everything. A frame in progress, including mid-XMIT, is abandoned with no partial output afterwards.

State machine (states IDLE, RECV, CMP, XMIT):
- IDLE:
  - X=1 at an edge starts a frame: go to RECV, cnt=0.
  - X=0: stay in IDLE.
- RECV:
  - Each edge shifts X into din from the LSB side, so the first bit ends up as the MSB, and increments cnt.
  - At the edge capturing bit WIDTH-1, go to CMP.
- CMP: lasts one cycle.
  - Forward condition: din != OLD_Q, or (FIRST_ALWAYS=1 and seen=0).
  - If the forward condition holds: OLD_Q<=din, dout<=din, seen<=1, FRAME_CNT<=FRAME_CNT+1 (wrapping), cnt=0, go to XMIT.
  - Otherwise: SKIP=1 for the next cycle, go to IDLE.
  - OLD_Q keeps its value while a frame is being received.
- XMIT: lasts WIDTH cycles.
  - Y=dout[WIDTH-1], Y_VALID=1; dout shifts left each edge; cnt increments.
  - After the WIDTH-th bit, go to IDLE.
  - X is ignored in CMP and XMIT. A start bit present during XMIT is lost, not queued.

Latency:
- Start bit sampled at edge t; data bits sampled at edges t+1..t+WIDTH; CMP occupies the cycle after edge t+WIDTH.
- Y_VALID is high from edge t+WIDTH+1 through edge t+2*WIDTH+1 (exactly WIDTH cycles).
- The earliest next start bit is sampled at edge t+2*WIDTH+2.
- A suppressed frame has IDLE re-entered at edge t+WIDTH+1. SKIP is high for that cycle, and a start bit can be sampled at edge t+WIDTH+2.

Boundaries:
- FRAME_CNT wraps from 2^CW-1 to 0.
- With FIRST_ALWAYS=0, a first frame equal to OLD_INIT is skipped.
- Back-to-back frames with no idle gap at the minimum spacing must work.

Optional Feature:
- Macro: SERIAL_DELTA_PARITY_EN.
- When defined:
  - After the WIDTH data bits, RECV captures one extra even-parity bit before CMP; all post-RECV timing shifts by +1.
  - A new output PAR_ERR (out, 1) pulses for one cycle when XOR(din, parity bit) != 0. The frame is then discarded: no compare, no OLD_Q update, no SKIP, FRAME_CNT unchanged, go to IDLE.
  - PAR_ERR resets to 0.
- When undefined: no parity bit, no PAR_ERR port, and timing is as above.

Test Plan (all with WIDTH=8):
- After reset, check every output at its reset value. Send start bit + 0xA5 → Y_VALID is high for 8 cycles beginning 9 cycles after the start-bit edge; Y carries 1,0,1,0,0,1,0,1; OLD_Q=0xA5; FRAME_CNT=1.
- Send 0xA5 again → SKIP pulses once, Y_VALID stays 0, FRAME_CNT remains 1. Then send 0x3C → 0x3C is forwarded and FRAME_CNT=2.
- With FIRST_ALWAYS=0 and OLD_INIT=0x00, send 0x00 first → SKIP and no output. Then send 0x01 → forwarded.
- Assert RESET on the 3rd XMIT bit → the next cycle has Y_VALID=0, OLD_Q=OLD_INIT and FRAME_CNT=0. A subsequent frame 0xA5 is forwarded normally.
- With CW=2, forward 5 distinct frames (0x01,0x02,0x03,0x04,0x05) back-to-back → FRAME_CNT reads 1,2,3,0,1. Also drive X=1 throughout XMIT → no extra frame is started.
- With SERIAL_DELTA_PARITY_EN, send 0x3C with parity bit 1 (wrong) → PAR_ERR pulses and OLD_Q is unchanged. Send 0x3C with parity bit 0 → forwarded, with Y_VALID starting one cycle later than in the non-parity build.
